scan_test_ctrl: RTL

Sequencer that runs one complete scan test on a `scan_chain_4`-style mux-D scan chain:
- shifts a stimulus pattern in;
- pulses one functional capture cycle;
- shifts the captured response out and compares it against an expected vector.

It sits between the test/BIST host logic and the chain's `scan_en`/`scan_in`/`scan_out` pins. It reports pass/fail and keeps a running failure count.

---
 rtl/scan_test_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: runs one complete scan test on a mux-D scan chain.
// The sequence is: shift the stimulus in (LOAD), one functional capture
// cycle (CAPT), then shift the response out (UNLOAD) and compare it with
// the golden vector. Results and a saturating failure count are registered
// on the completion edge.
//
// Handshake: a request is taken when start is sampled high while IDLE and
// abort is low. There is no ready/acknowledge signal and no queuing; a
// start seen while busy is dropped. done is a single-cycle completion
// strobe. pass/response are stable from done until the next done.
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 scan_out_i,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response,
    output logic [7:0]           err_cnt
);

    // Wide enough to hold CHAIN_LEN-1 without wrapping inside a phase.
    localparam int CW = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CAPT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        bit_cnt;
    logic [CHAIN_LEN-1:0] stim_sr;
    logic [CHAIN_LEN-1:0] exp_r;
    logic [CHAIN_LEN-1:0] resp_sr;
    logic [CHAIN_LEN-1:0] resp_final;
    logic                 phase_last;
    logic                 accept;
    logic                 finish;

    // Last bit of a LOAD or UNLOAD phase.
    assign phase_last = (bit_cnt == LAST_BIT);

    // A start with a simultaneous abort is not accepted.
    assign accept = (state == IDLE) && start && !abort;

    // Test completes on the last UNLOAD edge unless aborted on that edge.
    assign finish = (state == UNLOAD) && phase_last && !abort;

    // Full response including the bit sampled on the completion edge;
    // the first bit sampled ends up in the MSB.
    assign resp_final = {resp_sr[CHAIN_LEN-2:0], scan_out_i};

    // Chain pins and busy decode from registered state only.
    assign scan_en = (state == LOAD) || (state == UNLOAD);
    assign scan_in = (state == LOAD) ? stim_sr[CHAIN_LEN-1] : 1'b0;
    assign busy    = (state != IDLE);

    // Next-state logic: abort outranks every phase advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (phase_last) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                state_nxt = UNLOAD;
            end
            UNLOAD: begin
                if (phase_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit counter: restarts on every state change, counts within a shift phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state_nxt != state) begin
            bit_cnt <= '0;
        end else if ((state == LOAD) || (state == UNLOAD)) begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Stimulus and golden vectors: latched on accept, stimulus shifts MSB-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_sr <= '0;
            exp_r   <= '0;
        end else if (accept) begin
            stim_sr <= pattern;
            exp_r   <= expected;
        end else if (state == LOAD) begin
            stim_sr <= {stim_sr[CHAIN_LEN-2:0], 1'b0};
        end
    end

    // Response collection: one chain bit per UNLOAD cycle, pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sr <= '0;
        end else if (accept) begin
            resp_sr <= '0;
        end else if (state == UNLOAD) begin
            resp_sr <= resp_final;
        end
    end

    // Result registers: updated only on a completed (non-aborted) test.
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            pass     <= 1'b0;
            response <= '0;
            err_cnt  <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                response <= resp_final;
                pass     <= (resp_final == exp_r);
                if ((resp_final != exp_r) && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
